// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and constants for the parametrised VGA timing generator
//   pattern_e   : test-pattern selector encoding
//   bar_colour  : 8-entry colour-bar table, bit0=R, bit1=G, bit2=B
//   CHECK_BIT   : x/y bit toggling the checkerboard (32x32 squares)
//   MOVE_*      : moving-bar width and per-frame step
package vga_pkg;

   typedef enum logic [2:0] {
      PAT_BARS     = 3'd0,
      PAT_GRAD     = 3'd1,
      PAT_CHECK    = 3'd2,
      PAT_WHITE    = 3'd3,
      PAT_BAR_MOVE = 3'd4
   } pattern_e;

   localparam int NUM_BARS   = 8;
   localparam int CHECK_BIT  = 5;
   localparam int MOVE_BAR_W = 16;
   localparam int MOVE_STEP  = 4;

   // Colour-bar table: white, yellow, cyan, green, magenta, red, blue, black.
   function automatic logic [2:0] bar_colour(input int idx);
      case (idx)
         0:       bar_colour = 3'b111;
         1:       bar_colour = 3'b011;
         2:       bar_colour = 3'b110;
         3:       bar_colour = 3'b010;
         4:       bar_colour = 3'b101;
         5:       bar_colour = 3'b001;
         6:       bar_colour = 3'b100;
         default: bar_colour = 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - combinational test-pattern source
//   x, y       : counter position of the pixel being generated
//   frame_cnt  : completed-frame count (drives the moving bar)
//   pattern    : latched pattern select
//   data       : NUM_CH channels of DATA_W bits; channel k follows colour role k mod 3
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int NUM_CH   = 3,
   parameter int DATA_W   = 8,
   parameter int FRAME_W  = 16,
   parameter int XW       = 10,
   parameter int YW       = 10
) (
   input  logic [XW-1:0]                  x,
   input  logic [YW-1:0]                  y,
   input  logic [FRAME_W-1:0]             frame_cnt,
   input  logic [2:0]                     pattern,
   output logic [NUM_CH-1:0][DATA_W-1:0]  data
);

   localparam int BAR_W   = (H_ACTIVE / NUM_BARS > 0) ? H_ACTIVE / NUM_BARS : 1;
   // Pixels at or beyond BAR_END are the leftover remainder and stay black.
   localparam int BAR_END = NUM_BARS * (H_ACTIVE / NUM_BARS);
   localparam logic [DATA_W-1:0] MAX = '1;

   pattern_e          pat;
   logic [31:0]       xe;
   logic [31:0]       ye;
   logic [63:0]       step_pos;
   logic [31:0]       mv_pos;
   logic [2:0]        col;
   logic [DATA_W-1:0] r_val;
   logic [DATA_W-1:0] g_val;
   logic [DATA_W-1:0] b_val;

   always_comb begin
      pat      = pattern_e'(pattern);
      xe       = 32'(x);
      ye       = 32'(y);
      step_pos = 64'(frame_cnt) * 64'(MOVE_STEP);
      mv_pos   = 32'(step_pos % 64'(H_ACTIVE));
      col      = 3'b000;
      r_val    = '0;
      g_val    = '0;
      b_val    = '0;
      case (pat)
         PAT_BARS: begin
            if (xe < BAR_END)
               col = bar_colour(int'(xe / BAR_W));
            r_val = {DATA_W{col[0]}};
            g_val = {DATA_W{col[1]}};
            b_val = {DATA_W{col[2]}};
         end
         PAT_GRAD: begin
            r_val = xe[DATA_W-1:0];
            g_val = ye[DATA_W-1:0];
            b_val = xe[DATA_W-1:0] + ye[DATA_W-1:0];
         end
         PAT_CHECK: begin
            if (xe[CHECK_BIT] ^ ye[CHECK_BIT]) begin
               r_val = MAX;
               g_val = MAX;
               b_val = MAX;
            end
         end
         PAT_WHITE: begin
            r_val = MAX;
            g_val = MAX;
            b_val = MAX;
         end
         PAT_BAR_MOVE: begin
            // Bar may run past the right edge; those pixels are simply not drawn.
            if (xe >= mv_pos && xe < mv_pos + MOVE_BAR_W && xe < H_ACTIVE) begin
               r_val = MAX;
               g_val = MAX;
               b_val = MAX;
            end
         end
         default: begin
            r_val = '0;
            g_val = '0;
            b_val = '0;
         end
      endcase
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      if (k % 3 == 0) begin : g_r
         assign data[k] = r_val;
      end else if (k % 3 == 1) begin : g_g
         assign data[k] = g_val;
      end else begin : g_b
         assign data[k] = b_val;
      end
   end

endmodule

// File: rtl/vga_timing_gen_param.sv
// rtl/vga_timing_gen_param.sv - parametrised VGA sync/blank/DE generator with test patterns
//   i_clk_pixel, i_rst_n : pixel clock, async active-low reset (release takes effect one edge later)
//   i_en                 : 1 advances counters; 0 freezes counters and every output
//   i_pattern_sel        : pattern select, latched at the last pixel of each frame
//   o_hsync, o_vsync     : syncs at H_SYNC_POL / V_SYNC_POL when asserted
//   o_blank, o_de        : blanking and data-enable
//   o_sof, o_eol         : start-of-frame and end-of-active-line pulses
//   o_x_pos, o_y_pos     : counter position of the pixel on the outputs
//   o_data               : NUM_CH x DATA_W pixel data, 0 while blanked
//   o_frame_cnt          : completed frames, wrapping
//   Optional: VGA_TIMING_BORDER_EN draws a one-pixel MAX border around the active area.
module vga_timing_gen_param
   import vga_pkg::*;
#(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int H_SYNC_POL = 0,
   parameter int V_SYNC_POL = 0,
   parameter int NUM_CH     = 3,
   parameter int DATA_W     = 8,
   parameter int FRAME_W    = 16,
   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int XW        = $clog2(H_TOTAL),
   localparam int YW        = $clog2(V_TOTAL)
) (
   input  logic                           i_clk_pixel,
   input  logic                           i_rst_n,
   input  logic                           i_en,
   input  logic [2:0]                     i_pattern_sel,
   output logic                           o_hsync,
   output logic                           o_vsync,
   output logic                           o_blank,
   output logic                           o_de,
   output logic                           o_sof,
   output logic                           o_eol,
   output logic [XW-1:0]                  o_x_pos,
   output logic [YW-1:0]                  o_y_pos,
   output logic [NUM_CH-1:0][DATA_W-1:0]  o_data,
   output logic [FRAME_W-1:0]             o_frame_cnt
);

   localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
   localparam int            HS_START = H_ACTIVE + H_FP;
   localparam int            HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int            VS_START = V_ACTIVE + V_FP;
   localparam int            VS_END   = V_ACTIVE + V_FP + V_SYNC;
   localparam logic          HS_ON    = 1'(H_SYNC_POL);
   localparam logic          VS_ON    = 1'(V_SYNC_POL);

   logic                          run;
   logic [XW-1:0]                 h;
   logic [YW-1:0]                 v;
   logic [2:0]                    pat;
   logic [FRAME_W-1:0]            frame_cnt;
   logic                          adv;
   logic                          h_last;
   logic                          v_last;
   logic                          active;
   logic                          hs_act;
   logic                          vs_act;
   logic [NUM_CH-1:0][DATA_W-1:0] pat_pix;
   logic [NUM_CH-1:0][DATA_W-1:0] pix;

   // run stays low for the first enabled edge after reset release so the
   // counters start from a clean, synchronous point.
   assign adv = i_en & run;

   always_comb begin
      h_last = (h == H_LAST);
      v_last = (v == V_LAST);
      active = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
      hs_act = (32'(h) >= HS_START) && (32'(h) < HS_END);
      vs_act = (32'(v) >= VS_START) && (32'(v) < VS_END);
   end

   vga_pattern_gen #(
      .H_ACTIVE (H_ACTIVE),
      .NUM_CH   (NUM_CH),
      .DATA_W   (DATA_W),
      .FRAME_W  (FRAME_W),
      .XW       (XW),
      .YW       (YW)
   ) u_pattern (
      .x         (h),
      .y         (v),
      .frame_cnt (frame_cnt),
      .pattern   (pat),
      .data      (pat_pix)
   );

`ifdef VGA_TIMING_BORDER_EN
   logic border;
   assign border = (h == '0) || (32'(h) == H_ACTIVE - 1) ||
                   (v == '0) || (32'(v) == V_ACTIVE - 1);
   assign pix    = border ? '1 : pat_pix;
`else
   assign pix    = pat_pix;
`endif

   always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
      if (!i_rst_n) begin
         run         <= 1'b0;
         h           <= '0;
         v           <= '0;
         pat         <= 3'd0;
         frame_cnt   <= '0;
         o_hsync     <= ~HS_ON;
         o_vsync     <= ~VS_ON;
         o_blank     <= 1'b1;
         o_de        <= 1'b0;
         o_sof       <= 1'b0;
         o_eol       <= 1'b0;
         o_x_pos     <= '0;
         o_y_pos     <= '0;
         o_data      <= '0;
      end else begin
         if (i_en)
            run <= 1'b1;
         if (adv) begin
            o_hsync <= hs_act ? HS_ON : ~HS_ON;
            o_vsync <= vs_act ? VS_ON : ~VS_ON;
            o_blank <= ~active;
            o_de    <= active;
            o_sof   <= (h == '0) && (v == '0);
            o_eol   <= active && (32'(h) == H_ACTIVE - 1);
            o_x_pos <= h;
            o_y_pos <= v;
            o_data  <= active ? pix : '0;
            if (h_last) begin
               h <= '0;
               if (v_last) begin
                  // Frame boundary: the only place the pattern may change.
                  v         <= '0;
                  pat       <= i_pattern_sel;
                  frame_cnt <= frame_cnt + 1'b1;
               end else begin
                  v <= v + 1'b1;
               end
            end else begin
               h <= h + 1'b1;
            end
         end
      end
   end

   assign o_frame_cnt = frame_cnt;

endmodule

// File: doc/vga_timing_gen_param.md
Name: vga_timing_gen_param

Overview:
Parametrised successor to the fixed 640x480 VGA generator. Produces hsync, vsync, blank and DE timing for any resolution and sync polarity, plus a runtime-selectable test-pattern source over NUM_CH channels of DATA_W bits. Runs in the pixel clock domain and feeds vga_to_dvi (or any TMDS/parallel sink) directly. Adds frame/line markers, a frame counter and enable gating.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, asserted level of hsync (0 = active-low)
V_SYNC_POL, 0, asserted level of vsync
NUM_CH, 3, colour channels (ch0=R, ch1=G, ch2=B; ch k>=3 mirrors ch k mod 3)
DATA_W, 8, bits per channel
FRAME_W, 16, frame counter width

Ports:
i_clk_pixel  in  1  pixel clock
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  1 = counters advance; 0 = freeze counters and all outputs
i_pattern_sel  in  3  test pattern select, sampled at frame boundary
o_hsync  out  1  horizontal sync, polarity H_SYNC_POL
o_vsync  out  1  vertical sync, polarity V_SYNC_POL
o_blank  out  1  1 outside active area
o_de  out  1  ~o_blank
o_sof  out  1  1-cycle pulse on pixel (0,0)
o_eol  out  1  1-cycle pulse on last active pixel of each active line
o_x_pos  out  $clog2(H_TOTAL)  horizontal counter of current output pixel
o_y_pos  out  $clog2(V_TOTAL)  vertical counter of current output pixel
o_data  out  [NUM_CH][DATA_W]  pixel data, 0 when blanked
o_frame_cnt  out  FRAME_W  completed frames, wraps

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counters h 0..H_TOTAL-1, v 0..V_TOTAL-1; h wraps to 0 and increments v; v wraps to 0 on h wrap at V_TOTAL-1.
- Active: h<H_ACTIVE && v<V_ACTIVE. hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync for the analogous v range (whole lines).
- All outputs registered: outputs reflect counter state with 1-cycle latency; x/y/data/syncs/de mutually aligned.
- Reset (async assert, sync release): h=v=0, frame_cnt=0, latched pattern=0; o_hsync=~H_SYNC_POL, o_vsync=~V_SYNC_POL, o_blank=1, o_de=0, o_sof=0, o_eol=0, o_data=0, o_x_pos=o_y_pos=0. First valid pixel (0,0) with o_sof=1 appears on the 2nd enabled rising edge after release.
- i_en=0: counters, latched pattern and every output hold; pulses (o_sof/o_eol) held high do not re-fire when i_en returns (they clear on the next enabled edge).
- Pattern latch: i_pattern_sel sampled when h=H_TOTAL-1 && v=V_TOTAL-1 with i_en=1; never changes mid-frame. frame_cnt increments on the same edge, wrapping 2^FRAME_W-1 -> 0.
- Patterns (MAX = all ones): 0 colour bars: 8 bars of width H_ACTIVE/8, order white,yellow,cyan,green,magenta,red,blue,black; channel k = MAX if bar-colour bit (k mod 3) set; remainder pixels x>=8*(H_ACTIVE/8) are black. 1 gradient: ch0=x[DATA_W-1:0], ch1=y[DATA_W-1:0], ch2=(x+y) truncated to DATA_W. 2 checkerboard 32x32: all channels MAX if x[5]^y[5] else 0. 3 solid white. 4 moving bar: 16-px white column at pos = (frame_cnt*4) mod H_ACTIVE, black elsewhere; pixels past H_ACTIVE-1 are clipped. 5-7: solid black.
- o_data forced to 0 whenever blanked, regardless of pattern.

Optional Feature:
VGA_TIMING_BORDER_EN: when defined, active pixels with x=0, x=H_ACTIVE-1, y=0 or y=V_ACTIVE-1 output all channels MAX, overriding every pattern. When undefined, no border logic exists and pattern output is unmodified.

Decomposition:
- vga_pkg: pattern_e enum (PAT_BARS..PAT_BAR_MOVE), 8-entry colour-bar table, checker size and bar-width/step constants.
- Sub-module vga_pattern_gen: combinational pattern from (x, y, frame_cnt, pattern); top holds counters, sync decode, latching and output registers.

Test Plan:
- Small params (H 8/2/2/2, V 4/1/1/1, POL=1): after reset, hsync high for exactly 2 of every 14 cycles, vsync high for 1 line of 7; o_sof once per 98 cycles.
- Reset mid-frame at (h=5,v=2): outputs return to reset values immediately; (0,0) with o_sof on 2nd edge after release.
- Pattern 0, H_ACTIVE=640: x=0 -> {FF,FF,FF}, x=80 -> {FF,FF,00}, x=639 -> {00,00,00}; blank region all 0.
- Change i_pattern_sel 0->2 mid-frame: no change until next frame; then (32,0)=FF, (32,32)=00.
- i_en low 20 cycles at h=3: all outputs and o_frame_cnt stable; resume continues from h=4 without skip.
- FRAME_W=2: after 4 frames o_frame_cnt wraps 3->0; with VGA_TIMING_BORDER_EN, pixel (0,1) = MAX under pattern 5.
